// File: rtl/ram_pkg.sv
// Shared types and helpers for the byte-masked simple-dual-port RAM.
package ram_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_t;

  // Widest word the shared merge helper handles; callers size-cast in and out.
  localparam int MAX_DW = 256;
  localparam int MAX_NB = MAX_DW / 8;

  function automatic int bytes(input int dw);
    return dw / 8;
  endfunction

  // Lane i takes d when be[i] is set, otherwise keeps old.
  function automatic logic [MAX_DW-1:0] merge_be(input logic [MAX_DW-1:0] old,
                                                 input logic [MAX_DW-1:0] d,
                                                 input logic [MAX_NB-1:0] be);
    logic [MAX_DW-1:0] r;
    r = old;
    for (int i = 0; i < MAX_NB; i++) begin
      if (be[i]) r[8*i +: 8] = d[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/ram_dp_be_if.sv
// Write/read/clear bus of ram_dp_be; the master drives requests, the RAM answers.
interface ram_dp_be_if
  import ram_pkg::*;
#(
  parameter int AW = 12,
  parameter int DW = 16
);
  logic                   clr;
  logic                   busy;
  logic                   we;
  logic [AW-1:0]          waddr;
  logic [bytes(DW)-1:0]   wbe;
  logic [DW-1:0]          d;
  logic                   re;
  logic [AW-1:0]          raddr;
  logic [DW-1:0]          q;
  logic                   qv;

  modport master (
    output clr, we, waddr, wbe, d, re, raddr,
    input  busy, q, qv
  );

  modport slave (
    input  clr, we, waddr, wbe, d, re, raddr,
    output busy, q, qv
  );
endinterface

// File: rtl/ram_clr_seq.sv
// Clear sequencer: sweeps every address with a zero write after reset or a clr request.
module ram_clr_seq
  import ram_pkg::*;
#(
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  output logic          busy,
  output logic          cwe,
  output logic [AW-1:0] caddr
);

  clr_state_t    state, state_nx;
  logic [AW-1:0] ca, ca_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= CLEAR;
      ca    <= '0;
    end else begin
      state <= state_nx;
      ca    <= ca_nx;
    end
  end

  // clr is only looked at in IDLE, so a pulse mid-sweep cannot restart it.
  always_comb begin
    state_nx = state;
    ca_nx    = ca;
    case (state)
      IDLE: begin
        if (clr) begin
          state_nx = CLEAR;
          ca_nx    = '0;
        end
      end
      CLEAR: begin
        ca_nx = ca + 1'b1;
        if (ca == '1) state_nx = IDLE;
      end
      default: begin
        state_nx = CLEAR;
        ca_nx    = '0;
      end
    endcase
  end

  assign busy  = (state == CLEAR);
  assign cwe   = busy;
  assign caddr = ca;

endmodule

// File: rtl/ram_dp_be.sv
// Simple-dual-port RAM with byte-masked writes, optional registered read with
// write-first forwarding, and a built-in clear sweep.
module ram_dp_be
  import ram_pkg::*;
#(
  parameter int AW     = 12,
  parameter int DW     = 16,
  parameter int RD_REG = 1
) (
  input  logic        clk,
  input  logic        rst,
  ram_dp_be_if.slave  bus
);

  if (DW % 8 != 0) begin : g_dw_chk
    $error("ram_dp_be: DW must be a multiple of 8");
  end

  logic [DW-1:0] mem [2**AW];
  logic          busy;
  logic          cwe;
  logic [AW-1:0] caddr;
  logic [DW-1:0] wr_word;
  logic          fwd;

  ram_clr_seq #(.AW(AW)) u_clr_seq (
    .clk   (clk),
    .rst   (rst),
    .clr   (bus.clr),
    .busy  (busy),
    .cwe   (cwe),
    .caddr (caddr)
  );

  assign bus.busy = busy;

  // Merged word serves both the array write and the same-address read bypass.
  assign wr_word = DW'(merge_be(MAX_DW'(mem[bus.waddr]), MAX_DW'(bus.d), MAX_NB'(bus.wbe)));
  assign fwd     = bus.we && (bus.waddr == bus.raddr);

  // Clear sweep has priority; user writes during busy are dropped.
  always_ff @(posedge clk) begin
    if (cwe) begin
      mem[caddr] <= '0;
    end else if (bus.we) begin
      mem[bus.waddr] <= wr_word;
    end
  end

  if (RD_REG != 0) begin : g_rd_reg
    logic [DW-1:0] q_p1;
    logic          vld_p1;

    // ---- stage p1: registered read ----
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        q_p1   <= '0;
        vld_p1 <= 1'b0;
      end else if (busy) begin
        q_p1   <= '0;
        vld_p1 <= 1'b0;
      end else begin
        vld_p1 <= bus.re;
        if (bus.re) q_p1 <= fwd ? wr_word : mem[bus.raddr];
      end
    end

    // Gating by busy makes q/qv drop the moment a sweep begins.
    assign bus.q  = busy ? '0 : q_p1;
    assign bus.qv = vld_p1 & ~busy;
  end else begin : g_rd_comb
    assign bus.q  = busy ? '0 : mem[bus.raddr];
    assign bus.qv = 1'b0;
  end

endmodule

// File: doc/ram_dp_be.md
# ram_dp_be

Parametrised simple-dual-port RAM, the successor to the single-port `load`/`addr`/`d`/`q` RAM. It has a separate write port and read port in one clock domain. Writes are byte-masked. Read latency is selectable between combinational and registered, and same-address reads during a write are forwarded. A built-in clear sequencer zeroes the whole array after reset or on request. It serves as working memory for the ch2 datapath and as the register/stack store for later chapters.

## Interface
- `AW`, 12: address width; depth = 2^AW words.
- `DW`, 16: data width; must be a multiple of 8.
- `RD_REG`, 1: 0 = combinational read, 1 = registered read with 1-cycle latency.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `clr`  in  1  clear request, sampled on the rising edge.
- `busy`  out  1  clear sweep in progress.
- `we`  in  1  write enable.
- `waddr`  in  AW  write address.
- `wbe`  in  DW/8  byte enables; bit i covers `d[8i+7:8i]`.
- `d`  in  DW  write data.
- `re`  in  1  read enable; used only when `RD_REG=1`.
- `raddr`  in  AW  read address.
- `q`  out  DW  read data.
- `qv`  out  1  read-data valid strobe; used only when `RD_REG=1`.

## Operation
- Clear FSM has two states: IDLE and CLEAR, plus an AW-bit sweep counter `ca`.
- `rst` asserted: state goes to CLEAR, `ca=0`, `busy=1`, `q=0`, `qv=0`. The array contents are not touched asynchronously.
- CLEAR: each cycle, write 0 to `mem[ca]`, then `ca<=ca+1`. After the cycle that writes address 2^AW-1, go to IDLE with `ca` wrapped to 0.
- IDLE with `clr=1`: go to CLEAR with `ca=0`. A `clr` pulse during CLEAR is ignored; it does not restart the sweep.
- While `busy=1`: `we` is ignored; `q` is forced to 0 and `qv=0`; `re` is ignored.
- Write (IDLE, `we=1`): at the edge, update each byte lane i with `wbe[i]=1` to the matching byte of `d`. Other lanes keep their value. `wbe=0` gives a no-op write.
- `RD_REG=0`: `q = mem[raddr]` combinationally. A write shows on `q` after the edge, as in the previous generation. `qv` is tied to 0.
- `RD_REG=1`: at the edge with `re=1`, `q` is loaded with `mem[raddr]` and `qv=1` for the next cycle.
  - If `re=0`, `q` holds its last value and `qv=0`.
- Read-during-write, registered mode, `we=1`, `re=1`, `waddr==raddr`: `q` returns the merged word.
  - Enabled lanes come from `d`; the other lanes come from old memory. This is write-first.
- Read-during-write, combinational mode: `q` shows the old word until the edge.
- `rst` asserted mid-sweep or mid-read: the sweep restarts from address 0; `qv` drops immediately.

## Timing
- Reset values: `busy=1`, `q=0`, `qv=0`, state CLEAR, `ca=0`.
- Clear duration: exactly 2^AW cycles from the first edge after `rst` falls, or from the edge that samples `clr`. `busy` is 0 in the following cycle.
- Write latency: 1 edge.
- Registered read latency: 1 edge. Back-to-back reads are accepted every cycle with no bubbles.
- `clr` and `we` on the same edge in IDLE: the write is performed, then CLEAR starts and overwrites the array with 0.

## Structure
- Package `ram_pkg` holds:
  - the clear-state enum `clr_state_t` {IDLE, CLEAR};
  - the `bytes(DW)=DW/8` constant function;
  - the `merge_be(old, d, be)` function, shared by the write path and the forwarding path.
- Sub-module `ram_clr_seq` holds the FSM, the `ca` counter and `busy`. It outputs `cwe`/`caddr` to the array write mux.
- Top level holds the array, the write mux (clear over user), the read register and the forwarding compare.
- Elaboration check: error if DW%8 != 0.

## Test plan
Use AW=4, DW=16, RD_REG=1 unless noted.
- Reset then idle:
  - `busy=1` for exactly 16 cycles, then 0.
  - Reads of addresses 0..15 return 0 with `qv=1` one cycle after each `re`.
- Byte masking:
  - Write addr 2 d=16'hAABB wbe=2'b11, then d=16'h1234 wbe=2'b01. Read addr 2 gives 16'hAA34.
  - Write addr 3 wbe=2'b00. Read addr 3 gives 0.
- Forwarding:
  - Mem[4]=16'h00FF. On the same edge, write addr 4 d=16'h1100 wbe=2'b10 and read addr 4. Next cycle `q=16'h11FF`, `qv=1`.
- Mid-operation clear:
  - Fill addrs 1..4 with 20,30,40,50. Pulse `clr`; pulse `clr` again 5 cycles later.
  - `busy` lasts exactly 16 cycles from the first pulse.
  - Writes during busy are dropped. All reads afterwards return 0.
- Async reset mid-sweep:
  - Assert `rst` between edges at sweep cycle 7. `qv` and `q` go to 0 immediately.
  - After release the sweep restarts and `busy` lasts 16 cycles.
- RD_REG=0 regression:
  - Replay the old load/addr sequence: write 20/30/40 to addrs 2/3/4 with wbe=2'b11.
  - Combinational `q` for addrs 1..4 shows 0,20,30,40.
